// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter
// Round-robin arbiter in front of the single integer ALU. Each cycle at most
// one ready requester wins. Its operands, select codes and tag are captured
// into a one-entry issue register that feeds the operand-select stage directly.

// Structural invariant monitor for the arbiter. The top instantiates it, and it
// holds only assertions.
module alu_issue_arbiter_checker #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input logic             clk,
  input logic             reset,
  input logic [N_REQ-1:0] req_ready,
  input logic [IW-1:0]    prio
);

  // At most one requester is granted in any cycle.
  assert property (@(posedge clk) $onehot0(req_ready))
    else $error("arbiter granted more than one requester");

  // No grant may be issued while reset is asserted.
  assert property (@(posedge clk) reset |-> (req_ready == {N_REQ{1'b0}}))
    else $error("arbiter granted during reset");

  // The priority pointer always names an existing requester.
  assert property (@(posedge clk) disable iff (reset) (int'(prio) < N_REQ))
    else $error("arbiter priority pointer out of range");

endmodule

module alu_issue_arbiter #(
  parameter  int XLEN      = 32,
  parameter  int N_REQ     = 4,
  parameter  int TAG_WIDTH = 5,
  localparam int IW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*XLEN-1:0]      req_rs1,
  input  logic [N_REQ*XLEN-1:0]      req_rs2,
  input  logic [N_REQ*XLEN-1:0]      req_imm,
  input  logic [N_REQ*XLEN-1:0]      req_pc,
  input  logic [N_REQ*2-1:0]         req_op1_src,
  input  logic [N_REQ-1:0]           req_op2_src,
  input  logic [N_REQ*TAG_WIDTH-1:0] req_tag,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [XLEN-1:0]            iss_rs1,
  output logic [XLEN-1:0]            iss_rs2,
  output logic [XLEN-1:0]            iss_imm,
  output logic [XLEN-1:0]            iss_pc,
  output logic [1:0]                 iss_op1_src,
  output logic                       iss_op2_src,
  output logic [TAG_WIDTH-1:0]       iss_tag,
  output logic [IW-1:0]              iss_grant_idx
);

  // op1 select codes: 0 = rs1, 1 = pc, 2 = zero. Code 3 is reserved, and the
  // ALU must never see it, so it collapses to "zero" on capture.
  function automatic logic [1:0] sanitize_op1_src(input logic [1:0] src);
    logic [1:0] res;
    case (src)
      2'd0:    res = 2'd0;
      2'd1:    res = 2'd1;
      2'd2:    res = 2'd2;
      default: res = 2'd2;
    endcase
    return res;
  endfunction

  logic [IW-1:0]        prio_r;
  logic                 found_s;
  logic [IW-1:0]        winner_s;
  logic                 load_en_s;
  logic                 grant_s;
  logic [IW-1:0]        next_prio_s;
  logic [XLEN-1:0]      sel_rs1_s;
  logic [XLEN-1:0]      sel_rs2_s;
  logic [XLEN-1:0]      sel_imm_s;
  logic [XLEN-1:0]      sel_pc_s;
  logic [1:0]           sel_op1_s;
  logic                 sel_op2_s;
  logic [TAG_WIDTH-1:0] sel_tag_s;

  // Rotating scan from prio: the first valid requester found wins.
  always_comb begin
    int idx;
    found_s  = 1'b0;
    winner_s = {IW{1'b0}};
    idx      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(prio_r) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx;
      end
      if (!found_s && req_valid[idx]) begin
        found_s  = 1'b1;
        winner_s = IW'(idx);
      end else begin
        found_s  = found_s;
        winner_s = winner_s;
      end
    end
  end

  // The issue register can accept new work when it is empty or being consumed.
  // Reset and flush both block acceptance.
  always_comb begin
    load_en_s = !reset && !flush && (!iss_valid || iss_ready);
    grant_s   = load_en_s && found_s;
    if (grant_s) begin
      req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
    end else begin
      req_ready = {N_REQ{1'b0}};
    end
  end

  // The next priority sits one past the winner, with an explicit wrap so that a
  // non-power-of-two N_REQ never reaches an index that does not exist.
  always_comb begin
    if (winner_s == IW'(N_REQ - 1)) begin
      next_prio_s = {IW{1'b0}};
    end else begin
      next_prio_s = winner_s + {{(IW-1){1'b0}}, 1'b1};
    end
  end

  // Pick the winning requester's slice from every packed request bus.
  always_comb begin
    int sel;
    sel       = int'(winner_s);
    sel_rs1_s = req_rs1[sel*XLEN +: XLEN];
    sel_rs2_s = req_rs2[sel*XLEN +: XLEN];
    sel_imm_s = req_imm[sel*XLEN +: XLEN];
    sel_pc_s  = req_pc[sel*XLEN +: XLEN];
    sel_op1_s = sanitize_op1_src(req_op1_src[sel*2 +: 2]);
    sel_op2_s = req_op2_src[sel];
    sel_tag_s = req_tag[sel*TAG_WIDTH +: TAG_WIDTH];
  end

  // Issue register and round-robin pointer. Reset clears everything. Flush
  // empties the register but leaves prio alone. When nothing is accepted, the
  // register holds its contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      iss_valid     <= 1'b0;
      iss_rs1       <= {XLEN{1'b0}};
      iss_rs2       <= {XLEN{1'b0}};
      iss_imm       <= {XLEN{1'b0}};
      iss_pc        <= {XLEN{1'b0}};
      iss_op1_src   <= 2'd0;
      iss_op2_src   <= 1'b0;
      iss_tag       <= {TAG_WIDTH{1'b0}};
      iss_grant_idx <= {IW{1'b0}};
      prio_r        <= {IW{1'b0}};
    end else if (flush) begin
      iss_valid <= 1'b0;
    end else if (grant_s) begin
      iss_valid     <= 1'b1;
      iss_rs1       <= sel_rs1_s;
      iss_rs2       <= sel_rs2_s;
      iss_imm       <= sel_imm_s;
      iss_pc        <= sel_pc_s;
      iss_op1_src   <= sel_op1_s;
      iss_op2_src   <= sel_op2_s;
      iss_tag       <= sel_tag_s;
      iss_grant_idx <= winner_s;
      prio_r        <= next_prio_s;
    end else if (load_en_s) begin
      iss_valid <= 1'b0;
    end else begin
      iss_valid <= iss_valid;
    end
  end

  alu_issue_arbiter_checker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_checker (
    .clk       (clk),
    .reset     (reset),
    .req_ready (req_ready),
    .prio      (prio_r)
  );

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter. A small reference model predicts
// the grant for every cycle and queues the expected captured operation. The
// queued entry is compared with the DUT's issue register after the edge.
module tb_alu_issue_arbiter;

  localparam int XLEN = 32;
  localparam int N    = 4;
  localparam int TW   = 5;
  localparam int IW   = 2;

  typedef struct {
    logic [IW-1:0]   idx;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [1:0]      op1;
    logic            op2;
    logic [TW-1:0]   tag;
  } op_t;

  logic              clk = 1'b0;
  logic              reset, flush, iss_ready, iss_valid;
  logic [N-1:0]      req_valid, req_ready;
  logic [N*XLEN-1:0] req_rs1, req_rs2, req_imm, req_pc;
  logic [N*2-1:0]    req_op1_src;
  logic [N-1:0]      req_op2_src;
  logic [N*TW-1:0]   req_tag;
  logic [XLEN-1:0]   iss_rs1, iss_rs2, iss_imm, iss_pc;
  logic [1:0]        iss_op1_src;
  logic              iss_op2_src;
  logic [TW-1:0]     iss_tag;
  logic [IW-1:0]     iss_grant_idx;

  logic [XLEN-1:0] d_rs1 [N];
  logic [XLEN-1:0] d_rs2 [N];
  logic [XLEN-1:0] d_imm [N];
  logic [XLEN-1:0] d_pc  [N];
  logic [1:0]      d_op1 [N];
  logic            d_op2 [N];
  logic [TW-1:0]   d_tag [N];

  op_t sb_q[$];
  op_t cur;
  int  m_prio;
  bit  m_valid;
  bit  m_known;
  int  n_checks;
  int  n_fail;
  logic [N-1:0] got;

  always #5 clk = ~clk;

  alu_issue_arbiter #(.XLEN(XLEN), .N_REQ(N), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm), .req_pc(req_pc),
    .req_op1_src(req_op1_src), .req_op2_src(req_op2_src), .req_tag(req_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_imm(iss_imm), .iss_pc(iss_pc),
    .iss_op1_src(iss_op1_src), .iss_op2_src(iss_op2_src), .iss_tag(iss_tag),
    .iss_grant_idx(iss_grant_idx)
  );

  task automatic load_data(input bit rnd);
    for (int i = 0; i < N; i++) begin
      if (rnd) begin
        d_rs1[i] = $urandom; d_rs2[i] = $urandom; d_imm[i] = $urandom; d_pc[i] = $urandom;
        d_op1[i] = 2'($urandom_range(3, 0)); d_op2[i] = 1'($urandom_range(1, 0));
        d_tag[i] = 5'($urandom_range(31, 0));
      end else begin
        d_rs1[i] = 32'h1000_0000 + 32'(i); d_rs2[i] = 32'h2000_0000 + 32'(i);
        d_imm[i] = 32'h0000_0100 * 32'(i + 1); d_pc[i] = 32'h0000_8000 + 32'(4 * i);
        d_op1[i] = 2'(i % 3); d_op2[i] = 1'(i % 2); d_tag[i] = 5'(10 + i);
      end
    end
  endtask

  // One clock cycle. Drive inputs, compare req_ready with the model and queue
  // the expected capture. After the edge, compare the issue register.
  task automatic step(input logic rst, input logic fl, input logic [N-1:0] v,
                      input logic ir, output logic [N-1:0] rdy);
    logic [N-1:0] exp_rdy;
    int w;
    op_t e;
    reset = rst; flush = fl; req_valid = v; iss_ready = ir;
    for (int i = 0; i < N; i++) begin
      req_rs1[i*XLEN +: XLEN] = d_rs1[i];
      req_rs2[i*XLEN +: XLEN] = d_rs2[i];
      req_imm[i*XLEN +: XLEN] = d_imm[i];
      req_pc[i*XLEN +: XLEN]  = d_pc[i];
      req_op1_src[i*2 +: 2]   = d_op1[i];
      req_op2_src[i]          = d_op2[i];
      req_tag[i*TW +: TW]     = d_tag[i];
    end
    #2;
    exp_rdy = '0;
    w = -1;
    if (!rst && !fl && (!m_valid || ir)) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_prio + k) % N;
        if (w < 0 && v[j]) w = j;
      end
    end
    if (w >= 0) exp_rdy[w] = 1'b1;
    rdy = req_ready;
    n_checks++;
    if (req_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL req_ready: got %b expected %b (t=%0t)", req_ready, exp_rdy, $time);
    end
    if (w >= 0) begin
      e.idx = IW'(w); e.rs1 = d_rs1[w]; e.rs2 = d_rs2[w]; e.imm = d_imm[w]; e.pc = d_pc[w];
      e.op1 = (d_op1[w] == 2'd3) ? 2'd2 : d_op1[w];
      e.op2 = d_op2[w]; e.tag = d_tag[w];
      sb_q.push_back(e);
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_prio = 0; m_known = 1;
      cur.idx = '0; cur.rs1 = '0; cur.rs2 = '0; cur.imm = '0; cur.pc = '0;
      cur.op1 = '0; cur.op2 = 1'b0; cur.tag = '0;
      sb_q.delete();
    end else if (fl) begin
      m_valid = 0; m_known = 0;
    end else if (!m_valid || ir) begin
      if (w >= 0) begin
        cur = sb_q.pop_front();
        m_valid = 1; m_known = 1; m_prio = (w + 1) % N;
      end else begin
        m_valid = 0; m_known = 0;
      end
    end
    #1;
    n_checks++;
    if (iss_valid !== m_valid) begin
      n_fail++;
      $display("FAIL iss_valid: got %b expected %b (t=%0t)", iss_valid, m_valid, $time);
    end
    if (m_known) begin
      n_checks++;
      if (iss_grant_idx !== cur.idx || iss_rs1 !== cur.rs1 || iss_rs2 !== cur.rs2 ||
          iss_imm !== cur.imm || iss_pc !== cur.pc || iss_op1_src !== cur.op1 ||
          iss_op2_src !== cur.op2 || iss_tag !== cur.tag) begin
        n_fail++;
        $display("FAIL iss_data: got idx=%0d rs1=%h rs2=%h imm=%h pc=%h op1=%0d op2=%0d tag=%0d expected idx=%0d rs1=%h rs2=%h imm=%h pc=%h op1=%0d op2=%0d tag=%0d",
                 iss_grant_idx, iss_rs1, iss_rs2, iss_imm, iss_pc, iss_op1_src, iss_op2_src, iss_tag,
                 cur.idx, cur.rs1, cur.rs2, cur.imm, cur.pc, cur.op1, cur.op2, cur.tag);
      end
    end
  endtask

  task automatic test_reset;
    load_data(0);
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 1'b0, 4'b1111, 1'b1, got);
      n_checks++;
      if (got !== 4'b0000 || iss_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: req_ready=%b iss_valid=%b expected 0000/0", got, iss_valid);
      end
    end
    step(1'b0, 1'b0, 4'b1111, 1'b1, got);
    n_checks++;
    if (got !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_grant: got %b expected 0001", got);
    end
    n_checks++;
    if (iss_grant_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_first_idx: got %0d expected 0", iss_grant_idx);
    end
  endtask

  task automatic test_round_robin;
    load_data(0);
    step(1'b1, 1'b0, 4'b0000, 1'b1, got);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 4'b1111, 1'b1, got);
      n_checks++;
      if (got !== (4'b0001 << (k % 4)) || iss_tag !== 5'(10 + (k % 4))) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: req_ready=%b tag=%0d expected requester %0d tag %0d",
                 k, got, iss_tag, k % 4, 10 + (k % 4));
      end
    end
  endtask

  task automatic test_backpressure;
    load_data(1);
    step(1'b1, 1'b0, 4'b0000, 1'b1, got);
    step(1'b0, 1'b0, 4'b0100, 1'b1, got);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, 4'b1111, 1'b0, got);
      n_checks++;
      if (got !== 4'b0000 || iss_grant_idx !== 2'd2 || iss_rs1 !== d_rs1[2]) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: req_ready=%b idx=%0d rs1=%h expected 0000/2/%h",
                 c, got, iss_grant_idx, iss_rs1, d_rs1[2]);
      end
    end
    step(1'b0, 1'b0, 4'b1111, 1'b1, got);
    n_checks++;
    if (got !== 4'b1000 || iss_grant_idx !== 2'd3) begin
      n_fail++;
      $display("FAIL bp_release: req_ready=%b idx=%0d expected 1000/3", got, iss_grant_idx);
    end
  endtask

  task automatic test_operand_routing;
    load_data(0);
    step(1'b1, 1'b0, 4'b0000, 1'b1, got);
    d_op1[1] = 2'd1; d_pc[1] = 32'h0000_1000; d_imm[1] = 32'h0000_0010; d_op2[1] = 1'b1;
    step(1'b0, 1'b0, 4'b0010, 1'b1, got);
    n_checks++;
    if (iss_op1_src !== 2'd1 || iss_pc !== 32'h0000_1000 || iss_imm !== 32'h0000_0010 ||
        iss_op2_src !== 1'b1) begin
      n_fail++;
      $display("FAIL operand_route: op1=%0d pc=%h imm=%h op2=%0d expected 1/00001000/00000010/1",
               iss_op1_src, iss_pc, iss_imm, iss_op2_src);
    end
    d_op1[1] = 2'd3;
    step(1'b0, 1'b0, 4'b0010, 1'b1, got);
    n_checks++;
    if (iss_op1_src !== 2'd2) begin
      n_fail++;
      $display("FAIL op1_reserved: got %0d expected 2", iss_op1_src);
    end
  endtask

  task automatic test_flush;
    load_data(1);
    step(1'b1, 1'b0, 4'b0000, 1'b1, got);
    step(1'b0, 1'b0, 4'b0001, 1'b0, got);
    step(1'b0, 1'b1, 4'b0100, 1'b0, got);
    n_checks++;
    if (got !== 4'b0000 || iss_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: req_ready=%b iss_valid=%b expected 0000/0", got, iss_valid);
    end
    step(1'b0, 1'b0, 4'b0101, 1'b1, got);
    n_checks++;
    if (got !== 4'b0100 || iss_grant_idx !== 2'd2) begin
      n_fail++;
      $display("FAIL flush_prio: req_ready=%b idx=%0d expected 0100/2", got, iss_grant_idx);
    end
  endtask

  task automatic test_wrap;
    load_data(1);
    step(1'b1, 1'b0, 4'b0000, 1'b1, got);
    step(1'b0, 1'b0, 4'b0100, 1'b1, got);
    step(1'b0, 1'b0, 4'b0011, 1'b1, got);
    n_checks++;
    if (got !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_grant0: got %b expected 0001", got);
    end
    step(1'b0, 1'b0, 4'b0011, 1'b1, got);
    n_checks++;
    if (got !== 4'b0010) begin
      n_fail++;
      $display("FAIL wrap_grant1: got %b expected 0010", got);
    end
  endtask

  task automatic test_back_to_back;
    step(1'b1, 1'b0, 4'b0000, 1'b1, got);
    for (int c = 0; c < 80; c++) begin
      load_data(1);
      step(($urandom_range(39, 0) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(7, 0) == 0) ? 1'b1 : 1'b0,
           4'($urandom_range(15, 0)),
           ($urandom_range(3, 0) != 0) ? 1'b1 : 1'b0, got);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_prio = 0; m_valid = 0; m_known = 0;
    reset = 1'b1; flush = 1'b0; iss_ready = 1'b0; req_valid = '0;
    req_rs1 = '0; req_rs2 = '0; req_imm = '0; req_pc = '0;
    req_op1_src = '0; req_op2_src = '0; req_tag = '0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_operand_routing();
    test_flush();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
